polar_encoder: RTL

Iterative polar encoder for the polar-code datapath: the transmit-side counterpart of the SC decoder's LLR processing elements. It accepts one K-bit message per handshake and places the message bits at the information positions of an N-bit vector u, with all frozen positions set to 0. It then applies the Arikan butterfly transform x = u·F^⊗n, one stage per clock, and presents the N-bit codeword on a valid/ready output port. Its codewords are the golden stimulus source for decoder benches and the encode path of the loopback system.

---
 rtl/polar_pkg.sv | 24 ++
 rtl/polar_butterfly_stage.sv | 34 +++
 rtl/polar_encoder.sv | 94 +++++++++
 3 files changed

// File: rtl/polar_pkg.sv
// Shared polar-code definitions: encoder state type, default code parameters
// and a popcount helper used for elaboration-time mask checks.
package polar_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ENC  = 2'd1,
    ST_OUT  = 2'd2
  } polar_enc_state_t;

  localparam int unsigned POLAR_N_LOG2    = 3;
  localparam int unsigned POLAR_K         = 4;
  localparam logic [7:0]  POLAR_INFO_MASK = 8'hE8;

  function automatic int unsigned popcount(input logic [63:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < 64; i++) begin
      c += 32'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/polar_butterfly_stage.sv
// One Arikan butterfly stage: x[i] ^= x[i + 2^s] for every i with bit s clear.
module polar_butterfly_stage
  import polar_pkg::*;
#(
  parameter int unsigned N_LOG2 = POLAR_N_LOG2
) (
  input  logic [(1 << N_LOG2)-1:0] x_in,
  input  logic [N_LOG2-1:0]        s,
  output logic [(1 << N_LOG2)-1:0] x_out
);

  localparam int unsigned N = 1 << N_LOG2;

  logic [N-1:0] stage_res [N_LOG2];

  // Every stage is built in parallel; the stage index only selects among them.
  for (genvar gs = 0; gs < N_LOG2; gs++) begin : g_stage
    for (genvar gi = 0; gi < N; gi++) begin : g_bit
      if (((gi >> gs) & 1) == 0) begin : g_upper
        assign stage_res[gs][gi] = x_in[gi] ^ x_in[gi + (1 << gs)];
      end else begin : g_lower
        assign stage_res[gs][gi] = x_in[gi];
      end
    end
  end

  always_comb begin
    x_out = x_in;
    for (int st = 0; st < N_LOG2; st++) begin
      if (s == N_LOG2'(st)) x_out = stage_res[st];
    end
  end

endmodule

// File: rtl/polar_encoder.sv
// Iterative polar encoder: maps a K-bit message onto the information positions
// of u, applies one butterfly stage per clock and offers the codeword on valid/ready.
module polar_encoder
  import polar_pkg::*;
#(
  parameter int unsigned                N_LOG2    = POLAR_N_LOG2,
  parameter int unsigned                K         = POLAR_K,
  parameter logic [(1 << N_LOG2)-1:0]   INFO_MASK = POLAR_INFO_MASK
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      msg_valid,
  output logic                      msg_ready,
  input  logic [K-1:0]              msg_data,
  output logic                      cw_valid,
  input  logic                      cw_ready,
  output logic [(1 << N_LOG2)-1:0]  cw_data,
  output logic                      busy
);

  localparam int unsigned N = 1 << N_LOG2;

  if (popcount(64'(INFO_MASK)) != K) begin : g_mask_check
    $error("polar_encoder: popcount(INFO_MASK) must equal K");
  end

  polar_enc_state_t  state, state_nxt;
  logic [N-1:0]      work;
  logic [N-1:0]      u_load;
  logic [N-1:0]      x_stage;
  logic [N_LOG2-1:0] cnt;
  logic              accept;

  // Information bit j lands on the j-th set bit of INFO_MASK (ascending index).
  for (genvar gi = 0; gi < N; gi++) begin : g_map
    if (INFO_MASK[gi]) begin : g_info
      localparam int unsigned RANK = popcount(64'(INFO_MASK) & ((64'd1 << gi) - 64'd1));
      assign u_load[gi] = msg_data[RANK];
    end else begin : g_frozen
      assign u_load[gi] = 1'b0;
    end
  end

  polar_butterfly_stage #(
    .N_LOG2 (N_LOG2)
  ) u_stage (
    .x_in  (work),
    .s     (cnt),
    .x_out (x_stage)
  );

  assign accept = (state == ST_IDLE) && msg_valid;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (msg_valid)                    state_nxt = ST_ENC;
      ST_ENC:  if (cnt == N_LOG2'(N_LOG2 - 1))   state_nxt = ST_OUT;
      ST_OUT:  if (cw_ready)                     state_nxt = ST_IDLE;
      default:                                   state_nxt = ST_IDLE;
    endcase
  end

  // Handshake flags are pure state decodes so neither port sees the other combinationally.
  always_comb begin
    msg_ready = 1'b0;
    cw_valid  = 1'b0;
    busy      = 1'b0;
    msg_ready = (state == ST_IDLE) && !rst;
    cw_valid  = (state == ST_OUT);
    busy      = (state != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      work <= '0;
      cnt  <= '0;
    end else if (accept) begin
      work <= u_load;
      cnt  <= '0;
    end else if (state == ST_ENC) begin
      work <= x_stage;
      cnt  <= cnt + N_LOG2'(1);
    end
  end

  assign cw_data = work;

endmodule
